mem_cmd_gen: RTL
================

Name: mem_cmd_gen

Overview:
- Upstream request generator for the Plasticine DRAM controller top.
- Accepts one strided-burst command (base, stride, count, direction) and expands it into `count` single requests on a valid/ready port.
- That port drives the controller top's enq_val / isWR / addr inputs and is throttled by its enq_rdy.
- Reports busy, an issued-request count and a one-cycle done pulse. Supports abort.

Parameters:
- ADDR_W, 64, request address width; matches the controller-top addr port.
- STRIDE_W, 32, command stride width in bytes; unsigned.
- CNT_W, 16, command request-count width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command accepted when cmd_val&cmd_rdy
- cmd_is_wr  in  1  direction: 1 = write, 0 = read
- cmd_base  in  ADDR_W  first request address
- cmd_stride  in  STRIDE_W  byte increment between requests
- cmd_count  in  CNT_W  number of requests; 0 is legal
- abort  in  1  terminate current command
- req_val  out  1  request valid; drives the controller-top enq_val
- req_rdy  in  1  downstream ready; driven by the controller-top enq_rdy
- req_is_wr  out  1  request direction; drives isWR
- req_addr  out  ADDR_W  request address; drives addr
- busy  out  1  high in ISSUE and DONE
- done  out  1  one-cycle pulse on normal completion
- issued_cnt  out  CNT_W  requests handshaken for the current or last command

Behaviour:
- Reset (synchronous, active-high, clk):
  - state=IDLE, req_val=0, done=0, busy=0, issued_cnt=0, req_addr=0, req_is_wr=0.
  - cmd_rdy=1 in the first cycle after reset deasserts.
  - Reset mid-command drops req_val next edge. No done pulse; the command is discarded.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - cmd_rdy=1; req_val=0.
  - On cmd_val: latch is_wr, stride and count; set req_addr=cmd_base; clear issued_cnt.
  - count!=0 -> ISSUE. count==0 -> DONE directly; zero requests issued.
- ISSUE:
  - cmd_rdy=0; req_val=1.
  - A command accepted in cycle N gives req_val=1 in cycle N+1.
  - Handshake = req_val & req_rdy. On each handshake, issued_cnt+1 and req_addr += zero-extended stride.
  - req_addr wraps modulo 2^ADDR_W with no flag.
  - While req_val & !req_rdy, req_addr and req_is_wr hold stable.
  - On the handshake where issued_cnt+1 == count -> DONE. req_val=0 in the next cycle (no bubble-less overlap with the next command).
  - stride==0 is legal: all requests use the same address.
- DONE:
  - done=1 for exactly one cycle; cmd_rdy=0; next -> IDLE.
  - A new command can be accepted at the earliest 2 cycles after the final handshake.
- abort:
  - Sampled only in ISSUE; ignored in IDLE and DONE.
  - abort with no handshake: next state IDLE, req_val=0, done not pulsed, issued_cnt holds.
  - abort in the same cycle as a handshake: the transfer counts (issued_cnt+1), then IDLE.
  - abort on the final handshake: final transfer counts, next state IDLE, no done pulse; abort takes priority.
- issued_cnt:
  - Never exceeds count.
  - Holds after done/abort until the next command is accepted.
- Outputs are registered except cmd_rdy, which is decoded from state.

Decomposition:
- Shared package mem_cmd_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, DONE=2'd2)
  - default widths ADDR_W=64, STRIDE_W=32, CNT_W=16
- Sub-module mem_req_addr_gen:
  - address accumulator: load base, step by stride on handshake, hold otherwise.
  - Keeps the datapath separate from the FSM.

Test Plan:
- Basic write burst: base=0x1000, stride=0x40, count=4, is_wr=1, req_rdy=1 -> addrs 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles; done at final+1; issued_cnt=4.
- Backpressure: count=3, req_rdy low 5 cycles on the 2nd request -> req_addr and req_is_wr stable throughout; exactly 3 handshakes; done once.
- Zero count and zero stride:
  - count=0 -> no req_val; done pulse 1 cycle after accept; issued_cnt=0.
  - stride=0, count=2 -> both addrs equal base.
- Wrap: base=0xFFFF_FFFF_FFFF_FFC0, stride=0x40, count=2 -> 2nd addr=0x0.
- Abort:
  - abort after 2 of 5 handshakes (no concurrent handshake) -> req_val=0 next cycle, issued_cnt=2, no done.
  - abort coincident with the 3rd handshake -> issued_cnt=3, no done.
- Reset mid-ISSUE -> next cycle req_val=0, busy=0, issued_cnt=0. A fresh command then runs normally.

Source files
------------

// File: rtl/mem_cmd_pkg.sv
// Shared types and default widths for the strided-burst request generator.
package mem_cmd_pkg;

    localparam int ADDR_W   = 64;
    localparam int STRIDE_W = 32;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_cmd_gen_addr.sv
// Request address accumulator: loads the burst base, advances by the
// zero-extended stride on each handshake, holds otherwise.
module mem_req_addr_gen #(
    parameter int ADDR_W   = 64,
    parameter int STRIDE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [ADDR_W-1:0]   base,
    input  logic [STRIDE_W-1:0] stride,
    output logic [ADDR_W-1:0]   addr
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // Wraps modulo 2^ADDR_W by plain truncation.
    always_comb begin
        addr_d = addr_q;
        if (load)
            addr_d = base;
        else if (step)
            addr_d = addr_q + ADDR_W'(stride);
    end

    always_ff @(posedge clk) begin
        if (reset)
            addr_q <= '0;
        else
            addr_q <= addr_d;
    end

    assign addr = addr_q;

endmodule

// File: rtl/mem_cmd_gen.sv
// Expands one strided-burst command into count single requests on a
// valid/ready port feeding the DRAM controller top.
module mem_cmd_gen
    import mem_cmd_pkg::*;
#(
    parameter int ADDR_W   = mem_cmd_pkg::ADDR_W,
    parameter int STRIDE_W = mem_cmd_pkg::STRIDE_W,
    parameter int CNT_W    = mem_cmd_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_val,
    output logic                cmd_rdy,
    input  logic                cmd_is_wr,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [STRIDE_W-1:0] cmd_stride,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic                abort,
    output logic                req_val,
    input  logic                req_rdy,
    output logic                req_is_wr,
    output logic [ADDR_W-1:0]   req_addr,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    issued_cnt
);

    state_e              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic                req_val_q, req_val_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load, step, hs;
    logic [CNT_W-1:0]    issued_inc;

    assign hs         = req_val_q & req_rdy;
    assign issued_inc = issued_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        stride_d = stride_q;
        count_d  = count_q;
        issued_d = issued_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_val) begin
                    load     = 1'b1;
                    is_wr_d  = cmd_is_wr;
                    stride_d = cmd_stride;
                    count_d  = cmd_count;
                    issued_d = '0;
                    state_d  = (cmd_count != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    step     = 1'b1;
                    issued_d = issued_inc;
                end
                // Abort wins over completion: the last transfer still counts, but no done.
                if (abort)
                    state_d = IDLE;
                else if (hs && (issued_inc == count_q))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_val_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            stride_q  <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            req_val_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            stride_q  <= stride_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
            req_val_q <= req_val_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    mem_req_addr_gen #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .base   (cmd_base),
        .stride (stride_d),
        .addr   (req_addr)
    );

    assign cmd_rdy    = (state_q == IDLE);
    assign req_val    = req_val_q;
    assign req_is_wr  = is_wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign issued_cnt = issued_q;

endmodule
